// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//   Instruction sequencer for a small 16-bit CPU. It fetches an instruction
//   word into ir and then runs one or two execute phases (EX0, EX1). During
//   these phases an external decoder looks at ir and state and returns control
//   bits. At the end of each instruction the block updates pc. The fetched
//   word 16'hFFFF puts the block into a HALT state that only rst clears.
//
// Ports
//   clk, rst        : clock; synchronous active-high reset
//   run             : enable; the block leaves IDLE and starts the next
//                     fetch only while run is high
//   mem_req/we/addr : memory request, write qualifier and address; all zero
//                     while no request is outstanding
//   mem_rdata/ack   : memory read data and completion, sampled while mem_req
//   ir              : instruction register (feeds the decoder)
//   state           : decoder execute phase, 0 = EX0, 1 = EX1
//   dec_*           : decoder results (pc select, second phase, reg write,
//                     memory read, memory write)
//   dat_addr        : data address for execute-phase memory accesses
//   br_off          : two's-complement relative pc offset
//   jmp_addr        : absolute pc target
//   pc              : program counter
//   reg_we          : gated register-file write strobe
//   halted          : high while in HALT
// ---------------------------------------------------------------------------
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] ir,
  output logic        state,
  input  logic [1:0]  dec_ps,
  input  logic        dec_ns,
  input  logic        dec_wr,
  input  logic        dec_memrd,
  input  logic        dec_memwr,
  input  logic [15:0] dat_addr,
  input  logic [15:0] br_off,
  input  logic [15:0] jmp_addr,
  output logic [15:0] pc,
  output logic        reg_we,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EX0   = 3'd2,
    S_EX1   = 3'd3,
    S_HALT  = 3'd4
  } seq_state_e;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  // pc select encodings returned by the decoder
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REL  = 2'b10;
  localparam logic [1:0] PS_ABS  = 2'b11;

  seq_state_e  fsm_q, fsm_d;
  logic [15:0] pc_q,  pc_d;
  logic [15:0] ir_q,  ir_d;

  logic        mem_op;     // current execute phase performs a memory access
  logic        ex_done;    // current execute phase completes on this clock
  logic        instr_end;  // instruction completes on this clock
  logic [15:0] pc_next;    // pc value selected by dec_ps

  assign mem_op = dec_memrd | dec_memwr;

  // pc target mux. The adds are 16 bits wide, so they wrap modulo 2^16 and
  // no carry is kept.
  always_comb begin
    pc_next = pc_q;
    unique case (dec_ps)
      PS_HOLD: pc_next = pc_q;
      PS_INC:  pc_next = pc_q + 16'd1;
      PS_REL:  pc_next = pc_q + br_off;
      PS_ABS:  pc_next = jmp_addr;
      default: pc_next = pc_q;
    endcase
  end

  // Next-state logic and outputs. Memory outputs are driven directly from the
  // current state, so a request shows up in the same cycle the state is
  // entered. This gives zero-wait memory a single-cycle handshake.
  always_comb begin
    fsm_d     = fsm_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    reg_we    = 1'b0;
    halted    = 1'b0;
    state     = 1'b0;
    ex_done   = 1'b0;
    instr_end = 1'b0;

    unique case (fsm_q)
      S_IDLE: begin
        if (run) fsm_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d  = mem_rdata;
          fsm_d = (mem_rdata == HALT_WORD) ? S_HALT : S_EX0;
        end
      end

      S_EX0, S_EX1: begin
        state = (fsm_q == S_EX1);
        if (mem_op) begin
          mem_req  = 1'b1;
          mem_addr = dat_addr;
          mem_we   = dec_memwr;
        end
        // A phase with no memory access finishes at once. Otherwise it waits
        // for mem_ack. reg_we is only asserted on the finishing clock.
        ex_done = !mem_op || mem_ack;
        if (ex_done) begin
          reg_we = dec_wr;
          // dec_ns is only looked at in EX0. EX1 always ends the instruction.
          if (fsm_q == S_EX0 && dec_ns) fsm_d = S_EX1;
          else                          instr_end = 1'b1;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: fsm_d = S_IDLE;
    endcase

    // pc changes only here, once per instruction. run is only checked at this
    // point, so dropping run mid-instruction lets the instruction finish.
    if (instr_end) begin
      pc_d  = pc_next;
      fsm_d = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= S_IDLE;
      pc_q  <= 16'h0000;
      ir_q  <= 16'h0000;
    end else begin
      fsm_q <= fsm_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
    end
  end

  assign pc = pc_q;
  assign ir = ir_q;

endmodule
